// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n. Optional ovf signal is present
// only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_n_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, sub, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
      input  ovf,
`endif
      input  busy, done, s, co
   );

   modport slave (
      input  start, sub, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
      output ovf,
`endif
      output busy, done, s, co
   );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per op.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_n #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_adder_n_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, r_q, s_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, co_q, busy_q, done_q;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   logic             sum_d, cout_d;
   logic [WIDTH-1:0] sum_v, r_d;

   // Full-adder cell; new sum bit enters the result register from the top.
   always_comb begin
      sum_d  = a_q[0] ^ b_q[0] ^ c_q;
      cout_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
      sum_v  = '0;
      sum_v[WIDTH-1] = sum_d;
      r_d    = (r_q >> 1) | sum_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         co_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  // Subtract is a + ~b + 1, so the carry-in is forced high.
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  c_q     <= bus.sub | bus.cin;
                  r_q     <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= cout_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  s_q     <= r_d;
                  co_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q   <= c_q ^ cout_d;
`endif
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.s    = s_q;
   assign bus.co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock; the only clock domain.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 cin  input  1  carry-in for add; sampled with start; ignored when sub=1.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking valid s/co.
REQ-011 s  output  WIDTH  registered result, held until the next completion.
REQ-012 co  output  1  registered carry-out of the MSB (sub: 1 = no borrow).

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> RUN on start, else DONE -> IDLE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored with no effect on the current operation.
REQ-015 On acceptance the block SHALL capture a, b' and c0 into internal shift registers and clear the bit counter.
- sub=0: b' = b, c0 = cin.
- sub=1: b' = ~b, c0 = 1.
REQ-016 Each RUN cycle SHALL process one bit, LSB first, with a single full-adder cell.
- sum = a_i ^ b'_i ^ c
- c <= majority(a_i, b'_i, c)
- The sum bit shifts into an internal result register.
REQ-017 busy SHALL be high exactly in RUN, i.e. for WIDTH consecutive cycles per operation.
REQ-018 At the edge processing bit WIDTH-1, s and co SHALL load the final result and done SHALL assert; latency is WIDTH cycles from the start-sampling edge to done visible.
REQ-019 done SHALL be high for exactly one cycle per completed operation.
REQ-020 s and co SHALL NOT change at any other time except reset.
REQ-021 The result SHALL equal (a + b' + c0) mod 2^WIDTH, with co being bit WIDTH of that sum.
REQ-022 Back-to-back operations: a start in the DONE cycle SHALL begin a new RUN on the next edge with no idle gap.
REQ-023 WIDTH=1 SHALL behave as a registered full adder with latency 1.

Reset
REQ-024 rst SHALL take priority over start in every state.
REQ-025 On rst the block SHALL enter IDLE and clear all outputs and internal state: busy=0, done=0, s=0, co=0 (and ovf=0 when present).
REQ-026 Reset during RUN SHALL abort the operation with no done pulse and no update to s/co.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add output port ovf (1 bit, registered).
- ovf = carry into MSB XOR carry out of MSB (signed two's-complement overflow).
- ovf updates at the same edge as s/co.
REQ-028 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 WIDTH=8, a=8'hFF, b=8'h01, cin=0, sub=0 -> after 8 cycles done=1, s=8'h00, co=1; busy high for 8 cycles.
REQ-030 WIDTH=8, a=8'h05, b=8'h07, sub=1, cin=1 -> s=8'hFE, co=0 (cin ignored).
REQ-031 SERIAL_ADDER_OVF_EN defined, a=8'h7F, b=8'h01, sub=0 -> s=8'h80, ovf=1; a=8'h10, b=8'h20 -> ovf=0.
REQ-032 Start 8'h0F+8'h01, assert rst for one cycle on the 3rd RUN cycle -> no done pulse, s=0, co=0, busy=0, state IDLE.
REQ-033 During RUN, apply start with different operands -> ignored; first result still 8'h10, done exactly once; then start in the DONE cycle with 8'h01+8'h01 -> second done exactly 8 cycles later with s=8'h02.
REQ-034 WIDTH=1, all 8 combinations of a/b/cin with sub=0 -> s/co match the full-adder truth table, each with latency 1.
